// File: rtl/fl_output_packer_pkg.sv
// Shared types and field layout for the FrameLink output packer.
// Header/trailer offsets are kept here so host-side software decoders can mirror them.
package fl_output_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER,
        ST_DISCARD
    } state_t;

    localparam int unsigned HDR_ENDPOINT_LSB = 0;
    localparam int unsigned HDR_TYPE_LSB     = 8;
    localparam int unsigned HDR_SEQ_LSB      = 16;

    localparam int unsigned TRL_BYTES_LSB    = 0;
    localparam int unsigned TRL_PARTS_LSB    = 16;
    localparam int unsigned TRL_BSAT_BIT     = 24;
    localparam int unsigned TRL_SOFV_BIT     = 25;

    localparam logic [15:0] BYTE_CNT_MAX     = 16'hFFFF;
    localparam logic [7:0]  PART_CNT_MAX     = 8'hFF;

endpackage

// File: rtl/fl_packer_counters.sv
// Saturating byte/part counters and sticky error flags for one captured frame.
module fl_packer_counters
    import fl_output_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REM_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic             i_eop,
    input  logic [REM_W-1:0] i_rem,
    input  logic             i_sof_viol,
    output logic [15:0]      o_byte_cnt,
    output logic [7:0]       o_part_cnt,
    output logic             o_byte_sat,
    output logic             o_sof_viol
);

    localparam logic [16:0] WORD_BYTES = 17'(DATA_WIDTH / 8);

    logic [15:0] r_byte_cnt;
    logic [7:0]  r_part_cnt;
    logic        r_byte_sat;
    logic        r_sof_viol;
    logic [16:0] w_inc;
    logic [16:0] w_sum;

    // One extra bit on the sum makes overflow detection a plain compare.
    always_comb begin
        w_inc = i_eop ? (17'(i_rem) + 17'd1) : WORD_BYTES;
        w_sum = {1'b0, r_byte_cnt} + w_inc;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= '0;
            r_part_cnt <= '0;
            r_byte_sat <= 1'b0;
            r_sof_viol <= 1'b0;
        end else if (i_clear) begin
            r_byte_cnt <= '0;
            r_part_cnt <= '0;
            r_byte_sat <= 1'b0;
            r_sof_viol <= 1'b0;
        end else if (i_update) begin
            if (w_sum > {1'b0, BYTE_CNT_MAX}) begin
                r_byte_cnt <= BYTE_CNT_MAX;
                r_byte_sat <= 1'b1;
            end else begin
                r_byte_cnt <= w_sum[15:0];
            end
            if (i_eop && (r_part_cnt != PART_CNT_MAX)) begin
                r_part_cnt <= r_part_cnt + 8'd1;
            end
            if (i_sof_viol) begin
                r_sof_viol <= 1'b1;
            end
        end
    end

    assign o_byte_cnt = r_byte_cnt;
    assign o_part_cnt = r_part_cnt;
    assign o_byte_sat = r_byte_sat;
    assign o_sof_viol = r_sof_viol;

endmodule

// File: rtl/fl_output_packer.sv
// Captures frames leaving the DUT and forwards them to the host wrapped in
// a header (endpoint/type/sequence) and a trailer (bytes/parts/error flags).
module fl_output_packer
    import fl_output_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [7:0]  ENDPOINT_ID = 8'h00,
    parameter logic [7:0]  TRANS_TYPE  = 8'h01,
    localparam int unsigned REM_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [REM_W-1:0]      RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [REM_W-1:0]      TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_EOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    output logic [15:0]           SEQ_NUM
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_seq;
    logic        r_first;
    logic        w_hdr_xfer;
    logic        w_data_xfer;
    logic        w_trl_xfer;
    logic [15:0] w_byte_cnt;
    logic [7:0]  w_part_cnt;
    logic        w_byte_sat;
    logic        w_sof_viol;

    assign w_hdr_xfer  = (r_state == ST_HEADER)  && !TX_DST_RDY_N;
    assign w_data_xfer = (r_state == ST_DATA)    && !RX_SRC_RDY_N && !TX_DST_RDY_N;
    assign w_trl_xfer  = (r_state == ST_TRAILER) && !TX_DST_RDY_N;

    fl_packer_counters #(
        .DATA_WIDTH (DATA_WIDTH),
        .REM_W      (REM_W)
    ) u_counters (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_clear    (w_trl_xfer),
        .i_update   (w_data_xfer),
        .i_eop      (!RX_EOP_N),
        .i_rem      (RX_REM),
        .i_sof_viol (!RX_SOF_N && !r_first),
        .o_byte_cnt (w_byte_cnt),
        .o_part_cnt (w_part_cnt),
        .o_byte_sat (w_byte_sat),
        .o_sof_viol (w_sof_viol)
    );

    // r_first marks the frame's own SOF word, which is the one SOF that is not a violation.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_seq   <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_trl_xfer) begin
                r_seq <= r_seq + 16'd1;
            end
            if (w_hdr_xfer) begin
                r_first <= 1'b1;
            end else if (w_data_xfer) begin
                r_first <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        TX_DATA      = '0;
        TX_REM       = '0;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!RX_SRC_RDY_N) begin
                    if (RX_SOF_N) begin
                        RX_DST_RDY_N = 1'b0;
                    end else begin
                        w_state_nxt = ENABLE ? ST_HEADER : ST_DISCARD;
                    end
                end
            end
            ST_HEADER: begin
                TX_DATA[HDR_ENDPOINT_LSB +: 8] = ENDPOINT_ID;
                TX_DATA[HDR_TYPE_LSB +: 8]     = TRANS_TYPE;
                TX_DATA[HDR_SEQ_LSB +: 16]     = r_seq;
                TX_REM       = '1;
                TX_SOF_N     = 1'b0;
                TX_SOP_N     = 1'b0;
                TX_EOP_N     = 1'b0;
                TX_SRC_RDY_N = 1'b0;
                if (w_hdr_xfer) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                TX_DATA      = RX_DATA;
                TX_REM       = RX_REM;
                TX_SOP_N     = RX_SOP_N;
                TX_EOP_N     = RX_EOP_N;
                TX_SRC_RDY_N = RX_SRC_RDY_N;
                RX_DST_RDY_N = TX_DST_RDY_N;
                if (w_data_xfer && !RX_EOF_N) begin
                    w_state_nxt = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                TX_DATA[TRL_BYTES_LSB +: 16] = w_byte_cnt;
                TX_DATA[TRL_PARTS_LSB +: 8]  = w_part_cnt;
                TX_DATA[TRL_BSAT_BIT]        = w_byte_sat;
                TX_DATA[TRL_SOFV_BIT]        = w_sof_viol;
                TX_REM       = '1;
                TX_EOF_N     = 1'b0;
                TX_SOP_N     = 1'b0;
                TX_EOP_N     = 1'b0;
                TX_SRC_RDY_N = 1'b0;
                if (w_trl_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                RX_DST_RDY_N = 1'b0;
                if (!RX_SRC_RDY_N && !RX_EOF_N) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign SEQ_NUM = r_seq;

endmodule

// File: tb/tb_fl_output_packer.sv
// Scoreboard bench for fl_output_packer: expected host words are queued as
// frames are driven and compared as the packer emits them.
module tb_fl_output_packer;

    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 1000;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  rem;
        logic        sof;
        logic        eof;
        logic        sop;
        logic        eop;
    } word_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic [31:0] RX_DATA;
    logic [1:0]  RX_REM;
    logic        RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N;
    logic        RX_DST_RDY_N;
    logic [31:0] TX_DATA;
    logic [1:0]  TX_REM;
    logic        TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N;
    logic        TX_DST_RDY_N = 1'b0;
    logic [15:0] SEQ_NUM;

    word_t       frm[$];
    logic [37:0] exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        stall_en = 1'b0;
    logic [15:0] m_seq = '0;

    fl_output_packer #(
        .DATA_WIDTH  (DW),
        .ENDPOINT_ID (8'h00),
        .TRANS_TYPE  (8'h01)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .ENABLE       (ENABLE),
        .RX_DATA      (RX_DATA),
        .RX_REM       (RX_REM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SOP_N     (RX_SOP_N),
        .RX_EOP_N     (RX_EOP_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .TX_DATA      (TX_DATA),
        .TX_REM       (TX_REM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SOP_N     (TX_SOP_N),
        .TX_EOP_N     (TX_EOP_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N),
        .SEQ_NUM      (SEQ_NUM)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Host-side backpressure, changed just after each rising edge.
    always @(posedge CLK) begin
        #1;
        TX_DST_RDY_N = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && TX_SRC_RDY_N === 1'b0 && TX_DST_RDY_N === 1'b0) begin
            check("tx_word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("tx_word", 64'({TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    function automatic void add(input logic [31:0] d, input logic [1:0] r,
                                input logic sof, input logic eof, input logic sop, input logic eop);
        word_t w;
        w.data = d; w.rem = r; w.sof = sof; w.eof = eof; w.sop = sop; w.eop = eop;
        frm.push_back(w);
    endfunction

    function automatic logic [37:0] hdr_vec(input logic [15:0] seq);
        return {seq, 8'h01, 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic logic [37:0] data_vec(input word_t w);
        return {w.data, w.rem, 1'b1, 1'b1, ~w.sop, ~w.eop};
    endfunction

    function automatic void expect_frame();
        logic [16:0] bytes = '0;
        logic [16:0] sum;
        logic [7:0]  parts = '0;
        logic        bsat  = 1'b0;
        logic        sofv  = 1'b0;
        logic        first = 1'b1;
        exp_q.push_back(hdr_vec(m_seq));
        foreach (frm[i]) begin
            exp_q.push_back(data_vec(frm[i]));
            sum = bytes + (frm[i].eop ? (17'(frm[i].rem) + 17'd1) : 17'd4);
            if (sum > 17'h0FFFF) begin
                bytes = 17'h0FFFF;
                bsat  = 1'b1;
            end else begin
                bytes = sum;
            end
            if (frm[i].eop && parts != 8'hFF) parts++;
            if (frm[i].sof && !first) sofv = 1'b1;
            first = 1'b0;
        end
        exp_q.push_back({6'b0, sofv, bsat, parts, bytes[15:0], 2'b11, 1'b1, 1'b0, 1'b0, 1'b0});
        m_seq++;
    endfunction

    task automatic rx_word(input word_t w);
        int unsigned n = 0;
        RX_DATA = w.data; RX_REM = w.rem;
        RX_SOF_N = ~w.sof; RX_EOF_N = ~w.eof; RX_SOP_N = ~w.sop; RX_EOP_N = ~w.eop;
        RX_SRC_RDY_N = 1'b0;
        @(negedge CLK);
        while (RX_DST_RDY_N !== 1'b0 && n < LIMIT) begin
            @(negedge CLK);
            n++;
        end
        check("rx_accept_in_time", 64'(n < LIMIT), 64'd1);
        @(posedge CLK);
        #1;
        RX_SRC_RDY_N = 1'b1;
    endtask

    task automatic drive_frame(input int unsigned start);
        for (int unsigned i = start; i < frm.size(); i++) rx_word(frm[i]);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 2 * LIMIT) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_src_rdy"}, 64'(TX_SRC_RDY_N), 64'd1);
        check({tag, "_tx_delims"}, 64'({TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}), 64'hF);
        check({tag, "_tx_data"}, 64'(TX_DATA), 64'd0);
        check({tag, "_rx_dst_rdy"}, 64'(RX_DST_RDY_N), 64'd1);
        check({tag, "_seq"}, 64'(SEQ_NUM), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; ENABLE = 1'b1;
        RX_DATA = '0; RX_REM = '0; RX_SRC_RDY_N = 1'b1;
        RX_SOF_N = 1'b1; RX_EOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Three-word frame; also checks the header appears one cycle after SOF.
        frm.delete();
        add(32'hA1A2A3A4, 2'd3, 1, 0, 1, 0);
        add(32'hB1B2B3B4, 2'd3, 0, 0, 0, 0);
        add(32'hC1C2C3C4, 2'd3, 0, 1, 0, 1);
        expect_frame();
        RX_DATA = frm[0].data; RX_REM = frm[0].rem;
        RX_SOF_N = 1'b0; RX_EOF_N = 1'b1; RX_SOP_N = 1'b0; RX_EOP_N = 1'b1;
        RX_SRC_RDY_N = 1'b0;
        @(negedge CLK);
        check("sof_held_in_idle", 64'(RX_DST_RDY_N), 64'd1);
        check("no_tx_in_idle", 64'(TX_SRC_RDY_N), 64'd1);
        @(negedge CLK);
        check("header_latency", 64'(TX_SRC_RDY_N), 64'd0);
        drive_frame(0);
        wait_drain("drain_frame1");
        check("seq_after_frame1", 64'(SEQ_NUM), 64'd1);

        // Two parts of 5 and 6 bytes under random host stalls.
        stall_en = 1'b1;
        frm.delete();
        add(32'h11111111, 2'd3, 1, 0, 1, 0);
        add(32'h22222222, 2'd0, 0, 0, 0, 1);
        add(32'h33333333, 2'd3, 0, 0, 1, 0);
        add(32'h44444444, 2'd1, 0, 1, 0, 1);
        expect_frame();
        drive_frame(0);
        wait_drain("drain_two_part");
        stall_en = 1'b0;

        // Stray words in IDLE are dropped, then reset lands mid-frame.
        frm.delete();
        add(32'h5A5A0001, 2'd3, 0, 0, 0, 0);
        add(32'h5A5A0002, 2'd1, 0, 1, 0, 1);
        drive_frame(0);
        check("seq_after_stray", 64'(SEQ_NUM), 64'(m_seq));
        frm.delete();
        add(32'h66660001, 2'd3, 1, 0, 1, 0);
        add(32'h66660002, 2'd3, 0, 0, 0, 0);
        exp_q.push_back(hdr_vec(m_seq));
        exp_q.push_back(data_vec(frm[0]));
        exp_q.push_back(data_vec(frm[1]));
        drive_frame(0);
        wait_drain("drain_before_reset");
        RESET_N = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midframe_reset");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        m_seq = '0;
        @(negedge CLK);
        check_reset_outputs("after_reset");
        frm.delete();
        add(32'h66660003, 2'd3, 0, 0, 0, 0);
        add(32'h66660004, 2'd2, 0, 1, 0, 1);
        drive_frame(0);

        // A disabled frame is absorbed; the next enabled frame still carries SEQ 0.
        ENABLE = 1'b0;
        frm.delete();
        add(32'h77770001, 2'd3, 1, 0, 1, 0);
        add(32'h77770002, 2'd3, 0, 1, 0, 1);
        drive_frame(0);
        ENABLE = 1'b1;
        check("seq_after_discard", 64'(SEQ_NUM), 64'd0);
        frm.delete();
        add(32'h88880001, 2'd2, 1, 1, 1, 1);
        expect_frame();
        drive_frame(0);
        wait_drain("drain_single_word");

        // Second SOF inside a frame.
        stall_en = 1'b1;
        frm.delete();
        add(32'h99990001, 2'd3, 1, 0, 1, 0);
        add(32'h99990002, 2'd3, 1, 0, 0, 0);
        add(32'h99990003, 2'd1, 0, 1, 0, 1);
        expect_frame();
        drive_frame(0);
        wait_drain("drain_sof_violation");
        stall_en = 1'b0;

        // 17000 words overflow the 16-bit byte count.
        frm.delete();
        add(32'hF0000000, 2'd3, 1, 0, 1, 0);
        for (int unsigned i = 1; i < 16999; i++) add(32'hF0000000 | i, 2'd3, 0, 0, 0, 0);
        add(32'hF0FFFFFF, 2'd3, 0, 1, 0, 1);
        expect_frame();
        drive_frame(0);
        wait_drain("drain_saturation");
        check("seq_final", 64'(SEQ_NUM), 64'(m_seq));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fl_output_packer.md
# fl_output_packer

Hardware output-side capture block for the FrameLink verification framework. It receives frames leaving the DUT and forwards them toward the host output path, which feeds software output wrappers and monitors. Each forwarded frame is wrapped with a header word carrying endpoint ID, transaction type and sequence number, and a trailer word carrying byte count, part count and error flags. It is the receiving counterpart of the generator/driver path that feeds the DUT.

## Interface
Parameters:
- DATA_WIDTH, 32 — FrameLink data width in bits; multiple of 8, ≥32.
- ENDPOINT_ID, 8'h00 — identifier placed in every header.
- TRANS_TYPE, 8'h01 — transaction type placed in every header.

Ports:
- CLK  in  1  — single clock.
- RESET_N  in  1  — asynchronous, active-low reset.
- ENABLE  in  1  — capture enable; sampled only at SOF acceptance in IDLE.
- RX_DATA  in  DATA_WIDTH  — DUT output data.
- RX_REM  in  log2(DATA_WIDTH/8)  — index of the last valid byte on EOP words.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  1 each  — frame/part delimiters, active-low.
- RX_SRC_RDY_N  in  1  — DUT word valid, active-low.
- RX_DST_RDY_N  out  1  — packer ready, active-low.
- TX_DATA  out  DATA_WIDTH  — host-side data.
- TX_REM  out  log2(DATA_WIDTH/8)  — index of the last valid byte on EOP words.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  — host-side delimiters.
- TX_SRC_RDY_N  out  1  — host-side valid.
- TX_DST_RDY_N  in  1  — host-side ready.
- SEQ_NUM  out  16  — sequence number of the next frame to be emitted.

## Operation
- Transfer rule: a word moves on a given side when that side's SRC_RDY_N=0 and DST_RDY_N=0 at the CLK rising edge.
- FSM states: IDLE, HEADER, DATA, TRAILER, DISCARD.
- IDLE:
  - TX_SRC_RDY_N=1.
  - RX word valid with SOF_N=1 (stray word): RX_DST_RDY_N=0, word dropped.
  - RX word valid with SOF_N=0: RX_DST_RDY_N=1, so the SOF word is held at the RX side and not accepted. Next state is HEADER if ENABLE=1, else DISCARD.
- HEADER:
  - Drive header word: [7:0]=ENDPOINT_ID, [15:8]=TRANS_TYPE, [31:16]=SEQ_NUM, upper bits 0.
  - SOF_N=SOP_N=EOP_N=0, EOF_N=1, REM=all ones.
  - RX_DST_RDY_N=1.
  - On TX transfer, go to DATA.
- DATA:
  - Pass-through: TX_DATA, TX_REM, TX_SOP_N, TX_EOP_N and TX_SRC_RDY_N come from the RX side; RX_DST_RDY_N=TX_DST_RDY_N (combinational).
  - TX_SOF_N and TX_EOF_N are forced to 1.
  - On the RX EOF word transfer, go to TRAILER.
- TRAILER:
  - Drive trailer word: [15:0]=byte count, [23:16]=part count, [24]=byte-count saturated, [25]=SOF violation, rest 0.
  - SOP_N=EOP_N=EOF_N=0, SOF_N=1, REM=all ones.
  - RX_DST_RDY_N=1.
  - On TX transfer: SEQ_NUM increments (wraps 0xFFFF→0), counters clear, go to IDLE.
- DISCARD:
  - RX_DST_RDY_N=0; all words are dropped.
  - On the EOF word transfer, go to IDLE. SEQ_NUM is unchanged.
- Counters, updated on each DATA transfer:
  - Byte count adds DATA_WIDTH/8 per word, or REM+1 on EOP words.
  - Byte count saturates at 0xFFFF and sets bit 24.
  - Part count increments on each EOP word and saturates at 0xFF.
- SOF_N=0 seen in DATA: word forwarded with SOF_N forced to 1, and flag bit 25 is set.
- A word with both SOF and EOF (single-word frame) produces header, one data word, then trailer.

## Timing
- Reset values: state IDLE, SEQ_NUM=0, counters 0, TX_SRC_RDY_N=1, all TX delimiters 1, TX_DATA=0, RX_DST_RDY_N=1.
- Latency:
  - RX SOF presented at cycle t: header valid on TX at t+1.
  - First data word accepted no earlier than t+2.
  - Trailer valid the cycle after the RX EOF transfer.
  - Minimum per-frame overhead: 3 cycles (IDLE detect, header, trailer).
- Data phase throughput is 1 word/cycle, zero added latency.
- TX backpressure holds header/trailer outputs stable until transferred.
- Reset mid-frame: the host sees a frame truncated without EOF. The remainder of the DUT frame is dropped as stray words in IDLE.
- ENABLE changes outside IDLE-SOF sampling have no effect on the frame in progress.

## Structure
- fl_output_packer_pkg holds:
  - the state enum;
  - header field offsets (ENDPOINT, TYPE, SEQ);
  - trailer field offsets and flag bit positions;
  - the saturation limits 16'hFFFF and 8'hFF.
- One sub-module: fl_packer_counters, holding the saturating byte/part counters, flags, clear and update.

## Test plan
- Single 3-word frame, 4-byte last word (REM=3), DATA_WIDTH=32, SEQ=0 → TX sequence: header 32'h0000_0100, 3 data words, trailer 32'h0001_000C; SEQ_NUM=1.
- Two-part frame (5 bytes + 6 bytes) with random TX_DST_RDY_N stalls → trailer byte count 11, part count 2; no RX word lost or duplicated.
- ENABLE=0 at SOF, then ENABLE=1 on the next frame → first frame fully absorbed, nothing on TX; second header carries SEQ=0.
- 17000-word frame at DATA_WIDTH=32 → trailer bits[15:0]=0xFFFF, bit 24=1.
- Stray non-SOF words in IDLE, then RESET_N pulsed mid-DATA → stray words dropped; after reset all outputs at reset values; next frame header shows SEQ=0.
- Second SOF inside a frame → forwarded with TX_SOF_N=1, trailer bit 25=1.
